// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port (instruction/data) arbiter in front of MainMemory
module mem_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IReq,
  input  logic [ADDR_WIDTH-1:0] IAddr,
  output logic                  IAck,
  output logic [DATA_WIDTH-1:0] IRData,
  input  logic                  DReq,
  input  logic                  DWe,
  input  logic [ADDR_WIDTH-1:0] DAddr,
  input  logic [DATA_WIDTH-1:0] DWData,
  output logic                  DAck,
  output logic [DATA_WIDTH-1:0] DRData,
  output logic                  MemWriteEnable,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemData,
  input  logic [DATA_WIDTH-1:0] MemOutData,
  output logic                  Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state;
  logic   last_grant;  // 1 = data port
  logic   grant_d;
  logic   grant_we;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  // A port being acknowledged this cycle is not eligible for a new grant.
  assign i_req  = IReq & ~IAck;
  assign d_req  = DReq & ~DAck;
  assign pick_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b0;
      grant_d        <= 1'b0;
      grant_we       <= 1'b0;
      IAck           <= 1'b0;
      DAck           <= 1'b0;
      IRData         <= '0;
      DRData         <= '0;
      MemWriteEnable <= 1'b0;
      MemAddress     <= '0;
      MemData        <= '0;
      Busy           <= 1'b0;
    end else begin
      IAck <= 1'b0;
      DAck <= 1'b0;
      case (state)
        IDLE: begin
          MemWriteEnable <= 1'b0;
          if (i_req || d_req) begin
            last_grant <= pick_d;
            grant_d    <= pick_d;
            grant_we   <= pick_d & DWe;
            MemAddress <= pick_d ? DAddr : IAddr;
            if (pick_d && DWe) begin
              MemData        <= DWData;
              MemWriteEnable <= 1'b1;
            end
            state <= ISSUE;
            Busy  <= 1'b1;
          end
        end
        ISSUE: begin
          // Memory samples address/write at the end of this cycle.
          MemWriteEnable <= 1'b0;
          if (grant_we) begin
            DAck  <= 1'b1;
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (grant_d) begin
            DRData <= MemOutData;
            DAck   <= 1'b1;
          end else begin
            IRData <= MemOutData;
            IAck   <= 1'b1;
          end
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          MemWriteEnable <= 1'b0;
          state          <= IDLE;
          Busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural MainMemory
module tb_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          IReq, DReq, DWe;
  logic [AW-1:0] IAddr, DAddr;
  logic [DW-1:0] DWData;
  logic          IAck, DAck, MemWriteEnable, Busy;
  logic [DW-1:0] IRData, DRData, MemData, MemOutData;
  logic [AW-1:0] MemAddress;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IRData(IRData),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
    .DAck(DAck), .DRData(DRData),
    .MemWriteEnable(MemWriteEnable), .MemAddress(MemAddress),
    .MemData(MemData), .MemOutData(MemOutData), .Busy(Busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (MemWriteEnable) mem[MemAddress] <= MemData;
    MemOutData <= mem[MemAddress];
  end

  typedef struct packed {
    logic          port;  // 1 = data port
    logic          wr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            vec = 0;
  int            err = 0;
  logic [DW-1:0] exp_dr = '0;
  int            we_cnt = 0;
  logic [AW-1:0] we_addr;
  logic [DW-1:0] we_data;

  task automatic check_ack(input logic port);
    exp_t e;
    vec++;
    if (sb.size() == 0) begin
      err++;
      $display("FAIL unexpected_ack port=%0d (none expected)", port);
    end else begin
      e = sb.pop_front();
      if (e.port != port) begin
        err++;
        $display("FAIL ack_order got port=%0d expected port=%0d", port, e.port);
      end else if (!port) begin
        if (IRData !== e.data) begin
          err++;
          $display("FAIL i_read_data got %0d expected %0d", IRData, e.data);
        end
      end else if (e.wr) begin
        if (DRData !== exp_dr) begin
          err++;
          $display("FAIL d_write_drdata_hold got %0d expected %0d", DRData, exp_dr);
        end
      end else begin
        if (DRData !== e.data) begin
          err++;
          $display("FAIL d_read_data got %0d expected %0d", DRData, e.data);
        end
        exp_dr = e.data;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_dr = '0;
      end else begin
        if (MemWriteEnable) begin
          we_cnt++;
          we_addr = MemAddress;
          we_data = MemData;
        end
        if (IAck) check_ack(1'b0);
        if (DAck) check_ack(1'b1);
      end
    end
  end

  task automatic expect_ack(input logic port, input logic wr, input logic [DW-1:0] data);
    exp_t e;
    e.port = port;
    e.wr   = wr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_req(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int exp_lat, input bit hold);
    int cnt = 0;
    bit got = 0;
    @(posedge clk); #1;
    if (port) begin
      DWe = we; DAddr = addr; DWData = wdata; DReq = 1'b1;
    end else begin
      IAddr = addr; IReq = 1'b1;
    end
    while (!got && cnt < 20) begin
      @(negedge clk);
      cnt++;
      got = port ? DAck : IAck;
    end
    if (hold) begin
      @(posedge clk); #1;
    end
    if (port) DReq = 1'b0; else IReq = 1'b0;
    if (!got) begin
      vec++; err++;
      $display("FAIL ack_timeout port=%0d addr=%0d waited %0d cycles", port, addr, cnt);
    end else if (exp_lat >= 0) begin
      vec++;
      if (cnt - 1 != exp_lat) begin
        err++;
        $display("FAIL latency port=%0d we=%0d got %0d expected %0d", port, we, cnt - 1, exp_lat);
      end
    end
  endtask

  task automatic chk_zero(input string name);
    vec++;
    if ({IAck, DAck, IRData, DRData, MemWriteEnable, MemAddress, MemData, Busy} !== '0) begin
      err++;
      $display("FAIL %s outputs not zero: iack=%0d dack=%0d ird=%0d drd=%0d we=%0d addr=%0d md=%0d busy=%0d expected all 0",
               name, IAck, DAck, IRData, DRData, MemWriteEnable, MemAddress, MemData, Busy);
    end
  endtask

  task automatic chk(input string name, input int got, input int expv);
    vec++;
    if (got != expv) begin
      err++;
      $display("FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; IReq = 0; DReq = 0; DWe = 0;
    IAddr = '0; DAddr = '0; DWData = '0;
    #12;
    chk_zero("reset_state");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: write then read back on the data port
    we_cnt = 0;
    expect_ack(1, 1, 16'd0);
    do_req(1, 1, 13'd0, 16'd563, 2, 0);
    chk("t1_we_cycles", we_cnt, 1);
    chk("t1_we_addr", int'(we_addr), 0);
    chk("t1_we_data", int'(we_data), 563);
    expect_ack(1, 0, 16'd563);
    do_req(1, 0, 13'd0, 16'd0, 3, 0);

    // Test 2: data-port write observed by instruction-port reads
    expect_ack(1, 1, 16'd0);
    do_req(1, 1, 13'd1, 16'd200, 2, 0);
    expect_ack(0, 0, 16'd200);
    do_req(0, 0, 13'd1, 16'd0, 3, 0);
    expect_ack(0, 0, 16'd563);
    do_req(0, 0, 13'd0, 16'd0, 3, 0);
    chk("t2_drdata_unchanged", int'(DRData), 563);

    // Test 3: simultaneous requests from reset alternate D, I, D, I ...
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      expect_ack(1, 0, 16'd563);
      expect_ack(0, 0, 16'd200);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) do_req(1, 0, 13'd0, 16'd0, -1, 0);
      end
      begin
        for (int k = 0; k < 4; k++) do_req(0, 0, 13'd1, 16'd0, -1, 0);
      end
    join

    // Test 4: DReq held through the DAck cycle must not be re-granted
    expect_ack(1, 0, 16'd563);
    do_req(1, 0, 13'd0, 16'd0, 3, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_busy_after_dack", int'(Busy), 0);
    end

    // Test 5a: reset during CAPTURE of an instruction read
    @(posedge clk); #1;
    IAddr = 13'd1; IReq = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5_reset_in_capture");
    IReq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 5b: reset during ISSUE of a data write; the write is lost
    @(posedge clk); #1;
    DWe = 1'b1; DAddr = 13'd0; DWData = 16'd999; DReq = 1'b1;
    @(posedge clk); #2;
    chk("t5_we_in_issue", int'(MemWriteEnable), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t5_reset_in_issue");
    DReq = 1'b0; DWe = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_ack(0, 0, 16'd563);
    do_req(0, 0, 13'd0, 16'd0, 3, 0);

    // Test 6: top-of-memory address does not alias word 0
    we_cnt = 0;
    expect_ack(1, 1, 16'd0);
    do_req(1, 1, 13'd8191, 16'hFFFF, 2, 0);
    chk("t6_we_addr", int'(we_addr), 8191);
    expect_ack(1, 0, 16'hFFFF);
    do_req(1, 0, 13'd8191, 16'd0, 3, 0);
    expect_ack(0, 0, 16'd563);
    do_req(0, 0, 13'd0, 16'd0, 3, 0);

    repeat (3) @(posedge clk);
    chk("pending_acks_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
